rv32i_fetch_pc_unit: RTL and testbench

RV32I_FETCH_PC_UNIT -- requirements
Module: rv32i_fetch_pc_unit

---
 rtl/rv32i_pkg.sv | 16 +
 rtl/rv32i_next_pc.sv | 46 ++++
 rtl/rv32i_fetch_pc_unit.sv | 104 ++++++++++
 tb/tb_rv32i_fetch_pc_unit.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I fetch / program-counter slice.
package rv32i_pkg;

  // Fetch sequencer states
  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FETCH = 1'b1
  } fetch_state_t;

  // PC loaded on reset unless the instance overrides it
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Sequential instruction stride in bytes
  localparam logic [31:0] PC_INCR = 32'd4;

endpackage

// File: rtl/rv32i_next_pc.sv
// Next-PC target selection and word-alignment check (purely combinational).
module rv32i_next_pc
  import rv32i_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        do_branch,
  input  logic        is_jal,
  input  logic        is_jalr,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_val,
  output logic [31:0] target,
  output logic        misaligned
);

  // JALR targets ignore bit 0 of the computed sum
  function automatic logic [31:0] clear_lsb(input logic [31:0] addr);
    return {addr[31:1], 1'b0};
  endfunction

  // Any set bit in [1:0] means the target is not on a word boundary
  function automatic logic is_unaligned(input logic [31:0] addr);
    return |addr[1:0];
  endfunction

  logic signed [31:0] base_s;
  logic signed [31:0] imm_s;
  logic signed [31:0] sum_s;

  assign imm_s = imm;
  assign sum_s = base_s + imm_s;

  // Pick the adder base and the final target by priority: JALR, then JAL/branch, then sequential
  always_comb begin
    base_s = pc;
    target = pc + PC_INCR;
    if (is_jalr) begin
      base_s = rs1_val;
      target = clear_lsb(sum_s);
    end else if (is_jal || do_branch) begin
      target = sum_s;
    end
  end

  assign misaligned = is_unaligned(target);

endmodule

// File: rtl/rv32i_fetch_pc_unit.sv
// RV32I instruction fetch sequencer and program counter.
// A two-state FSM issues one memory read at pc per fetch_start and latches
// the returned word; the PC advances only on pc_update while idle.
module rv32i_fetch_pc_unit
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        fetch_start,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        busy,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        pc_update,
  input  logic        do_branch,
  input  logic        is_jal,
  input  logic        is_jalr,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_val,
  output logic        misaligned
);

  fetch_state_t state;
  logic [31:0]  target;
  logic         target_misaligned;
  logic         update_ok;

  rv32i_next_pc u_next_pc (
    .pc         (pc),
    .do_branch  (do_branch),
    .is_jal     (is_jal),
    .is_jalr    (is_jalr),
    .imm        (imm),
    .rs1_val    (rs1_val),
    .target     (target),
    .misaligned (target_misaligned)
  );

  // A PC commit is only legal while no fetch is outstanding
  assign update_ok = pc_update && (state == S_IDLE);

  // Fetch FSM with registered request/status outputs; a simultaneous
  // pc_update wins over fetch_start so the fetch uses the new PC
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      mem_req     <= 1'b0;
      busy        <= 1'b0;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (fetch_start && !pc_update) begin
            state       <= S_FETCH;
            mem_req     <= 1'b1;
            busy        <= 1'b1;
            instr_valid <= 1'b0;
          end
        end
        S_FETCH: begin
          if (mem_ready) begin
            state       <= S_IDLE;
            mem_req     <= 1'b0;
            busy        <= 1'b0;
            instr       <= mem_rdata;
            instr_valid <= 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          mem_req <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // PC register: a misaligned target leaves pc in place and raises the flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc         <= RESET_PC;
      misaligned <= 1'b0;
    end else if (update_ok) begin
      if (target_misaligned) begin
        misaligned <= 1'b1;
      end else begin
        pc         <= target;
        misaligned <= 1'b0;
      end
    end
  end

  assign mem_addr = pc;
  assign pc_plus4 = pc + PC_INCR;

endmodule

// File: tb/tb_rv32i_fetch_pc_unit.sv
// Self-checking bench for rv32i_fetch_pc_unit.
module tb_rv32i_fetch_pc_unit;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        resetn;
  logic        fetch_start;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        busy;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pc_update;
  logic        do_branch;
  logic        is_jal;
  logic        is_jalr;
  logic [31:0] imm;
  logic [31:0] rs1_val;
  logic        misaligned;

  int checks = 0;
  int errors = 0;

  logic [31:0] instr_q[$];
  logic [32:0] pc_q[$];
  logic [31:0] cur_pc;
  logic        cur_mis;

  rv32i_fetch_pc_unit #(.RESET_PC(TB_RESET_PC)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .fetch_start (fetch_start),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .busy        (busy),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .pc_update   (pc_update),
    .do_branch   (do_branch),
    .is_jal      (is_jal),
    .is_jalr     (is_jalr),
    .imm         (imm),
    .rs1_val     (rs1_val),
    .misaligned  (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference next-PC: returns {misaligned, new_pc}
  function automatic logic [32:0] model_next(input logic [31:0] p, input logic db,
                                             input logic jal, input logic jalr,
                                             input logic [31:0] im, input logic [31:0] r1);
    logic [31:0] t;
    if (jalr) t = (r1 + im) & 32'hFFFF_FFFE;
    else if (jal || db) t = p + im;
    else t = p + 32'd4;
    if (t[1:0] != 2'b00) return {1'b1, p};
    return {1'b0, t};
  endfunction

  task automatic clear_ctrl();
    pc_update = 1'b0; do_branch = 1'b0; is_jal = 1'b0; is_jalr = 1'b0;
    imm = 32'h0; rs1_val = 32'h0;
  endtask

  // One pc_update; expectation pushed with the stimulus, popped after the edge
  task automatic do_update(input logic db, input logic jal, input logic jalr,
                           input logic [31:0] im, input logic [31:0] r1,
                           input logic [31:0] exp_pc, input logic exp_mis, input string tag);
    logic [32:0] e;
    @(negedge clk);
    do_branch = db; is_jal = jal; is_jalr = jalr; imm = im; rs1_val = r1; pc_update = 1'b1;
    pc_q.push_back({exp_mis, exp_pc});
    @(posedge clk); #1;
    e = pc_q.pop_front();
    checks++;
    if (pc !== e[31:0]) begin errors++; $display("FAIL %s pc got %h exp %h", tag, pc, e[31:0]); end
    checks++;
    if (misaligned !== e[32]) begin errors++; $display("FAIL %s misaligned got %b exp %b", tag, misaligned, e[32]); end
    checks++;
    if (pc_plus4 !== e[31:0] + 32'd4) begin errors++; $display("FAIL %s pc_plus4 got %h exp %h", tag, pc_plus4, e[31:0] + 32'd4); end
    cur_pc = exp_pc;
    cur_mis = exp_mis;
    @(negedge clk);
    clear_ctrl();
  endtask

  task automatic set_pc(input logic [31:0] t);
    do_update(1'b0, 1'b1, 1'b0, t - cur_pc, 32'h0, t, 1'b0, "set_pc");
  endtask

  // One fetch with a given number of wait states; optional fetch_start pulse mid-fetch
  task automatic do_fetch(input logic [31:0] data, input int waits, input bit pulse, input string tag);
    int edges;
    int req_edges;
    logic [31:0] e;
    logic [31:0] exp_addr;
    @(negedge clk);
    fetch_start = 1'b1; mem_rdata = data; mem_ready = (waits == 0);
    instr_q.push_back(data);
    exp_addr = cur_pc;
    edges = 0; req_edges = 0;
    forever begin
      @(posedge clk); #1;
      edges++;
      if (mem_req) req_edges++;
      if (instr_valid || edges >= 30) break;
      if (edges == 1) begin
        checks++;
        if (mem_req !== 1'b1 || busy !== 1'b1 || mem_addr !== exp_addr) begin
          errors++;
          $display("FAIL %s start req/busy/addr got %b/%b/%h exp 1/1/%h", tag, mem_req, busy, mem_addr, exp_addr);
        end
      end
      @(negedge clk);
      fetch_start = pulse && (edges == 2);
      mem_ready = (edges >= waits + 1);
    end
    e = instr_q.pop_front();
    checks++;
    if (edges !== waits + 2) begin errors++; $display("FAIL %s latency got %0d exp %0d", tag, edges, waits + 2); end
    checks++;
    if (req_edges !== waits + 1) begin errors++; $display("FAIL %s mem_req edges got %0d exp %0d", tag, req_edges, waits + 1); end
    checks++;
    if (instr !== e) begin errors++; $display("FAIL %s instr got %h exp %h", tag, instr, e); end
    checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL %s done req/busy got %b/%b exp 0/0", tag, mem_req, busy); end
    @(negedge clk);
    fetch_start = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (instr_valid !== 1'b1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL %s hold valid/req got %b/%b exp 1/0", tag, instr_valid, mem_req);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b1;
    #2 resetn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (pc !== TB_RESET_PC) begin errors++; $display("FAIL reset pc got %h exp %h", pc, TB_RESET_PC); end
    checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset req/busy got %b/%b exp 0/0", mem_req, busy); end
    checks++;
    if (instr !== 32'h0 || instr_valid !== 1'b0) begin errors++; $display("FAIL reset instr got %h/%b exp 0/0", instr, instr_valid); end
    checks++;
    if (misaligned !== 1'b0) begin errors++; $display("FAIL reset misaligned got %b exp 0", misaligned); end
    checks++;
    if (pc_plus4 !== TB_RESET_PC + 32'd4) begin errors++; $display("FAIL reset pc_plus4 got %h exp %h", pc_plus4, TB_RESET_PC + 32'd4); end
    resetn = 1'b1;
    cur_pc = TB_RESET_PC;
    cur_mis = 1'b0;
  endtask

  task automatic test_fetch_zero_wait();
    do_fetch(32'h0000_0013, 0, 1'b0, "fetch_zero_wait");
  endtask

  task automatic test_fetch_wait_states();
    do_fetch(32'h00A0_0093, 3, 1'b1, "fetch_wait3");
  endtask

  task automatic test_branch_jump();
    set_pc(32'h100);
    do_update(1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0, 32'h0000_00F8, 1'b0, "branch_neg");
    set_pc(32'h100);
    do_update(1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0, 32'h0000_0104, 1'b0, "not_taken");
    set_pc(32'h100);
    do_update(1'b1, 1'b1, 1'b1, 32'h3, 32'h201, 32'h0000_0204, 1'b0, "jalr_prio");
    do_update(1'b0, 1'b0, 1'b1, 32'h0, 32'h201, 32'h0000_0200, 1'b0, "jalr_lsb");
  endtask

  task automatic test_misaligned();
    set_pc(32'h100);
    do_update(1'b0, 1'b1, 1'b0, 32'h6, 32'h0, 32'h0000_0100, 1'b1, "jal_misaligned");
    do_fetch(32'h1234_5678, 1, 1'b0, "fetch_keeps_mis");
    checks++;
    if (misaligned !== 1'b1) begin errors++; $display("FAIL mis_hold got %b exp 1", misaligned); end
    do_update(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0104, 1'b0, "mis_clear");
    do_update(1'b0, 1'b0, 1'b1, 32'h0, 32'h102, 32'h0000_0104, 1'b1, "jalr_misaligned");
    do_update(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0108, 1'b0, "mis_clear2");
  endtask

  task automatic test_update_with_start();
    logic [31:0] e;
    @(negedge clk);
    pc_update = 1'b1; fetch_start = 1'b1;
    e = cur_pc + 32'd4;
    @(posedge clk); #1;
    checks++;
    if (pc !== e || mem_req !== 1'b0 || busy !== 1'b0 || instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL update_with_start pc/req/busy/valid got %h/%b/%b/%b exp %h/0/0/1", pc, mem_req, busy, instr_valid, e);
    end
    cur_pc = e;
    @(negedge clk);
    pc_update = 1'b0; fetch_start = 1'b0;
  endtask

  task automatic test_random_updates();
    logic [32:0] m;
    logic [31:0] im;
    logic [31:0] r1;
    logic db, jal, jalr;
    for (int i = 0; i < 10; i++) begin
      im = $urandom & 32'h0000_0FFE;
      if (im[11]) im = 32'h0 - im;
      r1 = $urandom & 32'h0000_FFFF;
      db = 1'($urandom_range(0, 1));
      jal = 1'($urandom_range(0, 1));
      jalr = ($urandom_range(0, 3) == 0);
      m = model_next(cur_pc, db, jal, jalr, im, r1);
      do_update(db, jal, jalr, im, r1, m[31:0], m[32], "random");
    end
  endtask

  task automatic test_wrap();
    set_pc(32'hFFFF_FFFC);
    checks++;
    if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap pc_plus4_before got %h exp 0", pc_plus4); end
    do_update(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0000, 1'b0, "wrap_seq");
  endtask

  task automatic test_update_in_fetch();
    logic [31:0] e;
    @(negedge clk);
    fetch_start = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    fetch_start = 1'b0;
    pc_update = 1'b1; do_branch = 1'b1; imm = 32'h40;
    @(posedge clk); #1;
    checks++;
    if (pc !== cur_pc || misaligned !== cur_mis || mem_req !== 1'b1) begin
      errors++;
      $display("FAIL update_in_fetch pc/mis/req got %h/%b/%b exp %h/%b/1", pc, misaligned, mem_req, cur_pc, cur_mis);
    end
    @(negedge clk);
    clear_ctrl();
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
    instr_q.push_back(32'hCAFE_F00D);
    @(posedge clk); #1;
    e = instr_q.pop_front();
    checks++;
    if (instr_valid !== 1'b1 || instr !== e) begin
      errors++; $display("FAIL update_in_fetch instr got %h/%b exp %h/1", instr, instr_valid, e);
    end
    @(negedge clk);
    mem_ready = 1'b0;
  endtask

  task automatic test_reset_mid_fetch();
    set_pc(32'h40);
    @(negedge clk);
    fetch_start = 1'b1; mem_ready = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_mid pre req got %b exp 1", mem_req); end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid req/busy got %b/%b exp 0/0", mem_req, busy); end
    checks++;
    if (pc !== TB_RESET_PC || instr_valid !== 1'b0 || instr !== 32'h0) begin
      errors++; $display("FAIL rst_mid pc/valid/instr got %h/%b/%h exp %h/0/0", pc, instr_valid, instr, TB_RESET_PC);
    end
    fetch_start = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    resetn = 1'b1;
    cur_pc = TB_RESET_PC; cur_mis = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (mem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0) begin
      errors++; $display("FAIL rst_mid after req/valid/instr got %b/%b/%h exp 0/0/0", mem_req, instr_valid, instr);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    do_fetch(32'h0050_0093, 1, 1'b0, "fetch_after_reset");
  endtask

  initial begin
    resetn = 1'b1; fetch_start = 1'b0; mem_ready = 1'b0; mem_rdata = 32'h0;
    clear_ctrl();
    cur_pc = TB_RESET_PC; cur_mis = 1'b0;
    test_reset();
    test_fetch_zero_wait();
    test_fetch_wait_states();
    test_branch_jump();
    test_misaligned();
    test_update_with_start();
    test_random_updates();
    test_wrap();
    test_update_in_fetch();
    test_reset_mid_fetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
